// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encoding, time-bus layout
// and BCD limits matching the clock stage's HH:MM:SS bus.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RINGING = 2'b01,
    ST_SNOOZE  = 2'b10
  } alarm_state_t;

  // time_bcd = {HT[1:0],HU[3:0],MT[2:0],MU[3:0],ST[2:0],SU[3:0]}
  localparam int TIME_W       = 20;
  localparam int HM_LSB       = 7;
  localparam int SEC_FIELD_W  = 7;
  localparam int ALARM_W      = TIME_W - HM_LSB;
  localparam int HOUR_TENS_W  = 2;
  localparam int MIN_TENS_W   = 3;

  localparam int HOUR_MAX     = 23;
  localparam int MIN_MAX      = 59;

  localparam int SEC_CNT_W    = 9;

  function automatic logic [7:0] bin_to_bcd8(input int v);
    bin_to_bcd8 = {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_updown.sv
// Two-digit BCD up/down counter wrapping between 00 and MAX, used for the
// alarm minute and hour fields. Simultaneous inc and dec cancel out.
module bcd_mod_updown
  import alarm_pkg::*;
#(
  parameter int MAX     = 59,
  parameter int TENS_W  = 3,
  parameter int RST_VAL = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                inc,
  input  logic                dec,
  output logic [TENS_W+3:0]   value
);

  localparam int W = TENS_W + 4;
  localparam logic [W-1:0]      MAX_V = W'(bin_to_bcd8(MAX));
  localparam logic [W-1:0]      RST_V = W'(bin_to_bcd8(RST_VAL));
  localparam logic [TENS_W-1:0] ONE_T = TENS_W'(1);

  logic [TENS_W-1:0] tens;
  logic [3:0]        units;
  logic [W-1:0]      value_nxt;

  assign tens  = value[W-1:4];
  assign units = value[3:0];

  always_comb begin
    value_nxt = value;
    if (en && inc && !dec) begin
      if (value == MAX_V)     value_nxt = '0;
      else if (units == 4'd9) value_nxt = {tens + ONE_T, 4'd0};
      else                    value_nxt = {tens, units + 4'd1};
    end else if (en && dec && !inc) begin
      if (value == '0)        value_nxt = MAX_V;
      else if (units == 4'd0) value_nxt = {tens - ONE_T, 4'd9};
      else                    value_nxt = {tens, units - 4'd1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value <= RST_V;
    else        value <= value_nxt;
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: compares a user-set HH:MM alarm against the running BCD
// time and runs the ring / snooze / stop state machine driving buzzer and LED.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int RST_HOUR    = 7,
  parameter int RST_MIN     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic [TIME_W-1:0]  time_bcd,
  input  logic               alarm_en,
  input  logic               set_mode,
  input  logic               inc_min,
  input  logic               dec_min,
  input  logic               inc_hour,
  input  logic               dec_hour,
  input  logic               stop_btn,
  input  logic               snooze_btn,
  output logic [ALARM_W-1:0] alarm_bcd,
  output logic               buzzer,
  output logic               alarm_led,
  output logic [1:0]         state
);

  localparam int SNZ_W = $clog2(MAX_SNOOZE + 1);
  localparam logic [SEC_CNT_W-1:0] RING_LAST   = SEC_CNT_W'(RING_SECS - 1);
  localparam logic [SEC_CNT_W-1:0] SNOOZE_LAST = SEC_CNT_W'(SNOOZE_SECS - 1);
  localparam logic [SNZ_W-1:0]     SNZ_MAX     = SNZ_W'(MAX_SNOOZE);

  alarm_state_t             state_q;
  logic [SEC_CNT_W-1:0]     sec_cnt;
  logic [SNZ_W-1:0]         snooze_cnt;
  logic                     match;
  logic                     match_q;
  logic                     trig;
  logic                     edit_en;
  logic [HOUR_TENS_W+3:0]   alarm_hour;
  logic [MIN_TENS_W+3:0]    alarm_min;

  assign edit_en   = set_mode && (state_q == ST_IDLE);
  assign alarm_bcd = {alarm_hour, alarm_min};
  assign state     = state_q;

  bcd_mod_updown #(
    .MAX     (MIN_MAX),
    .TENS_W  (MIN_TENS_W),
    .RST_VAL (RST_MIN)
  ) u_min (
    .clk   (clk),
    .reset (reset),
    .en    (edit_en),
    .inc   (inc_min),
    .dec   (dec_min),
    .value (alarm_min)
  );

  bcd_mod_updown #(
    .MAX     (HOUR_MAX),
    .TENS_W  (HOUR_TENS_W),
    .RST_VAL (RST_HOUR)
  ) u_hour (
    .clk   (clk),
    .reset (reset),
    .en    (edit_en),
    .inc   (inc_hour),
    .dec   (dec_hour),
    .value (alarm_hour)
  );

  // Raw BCD compare: an invalid digit on the bus can never equal a valid alarm.
  assign match = alarm_en
              && (time_bcd[TIME_W-1:HM_LSB] == alarm_bcd)
              && (time_bcd[SEC_FIELD_W-1:0] == '0);
  assign trig  = match && !match_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      buzzer     <= 1'b0;
      alarm_led  <= 1'b0;
      sec_cnt    <= '0;
      snooze_cnt <= '0;
      match_q    <= 1'b0;
    end else begin
      match_q <= match;
      if (!alarm_en) begin
        state_q    <= ST_IDLE;
        buzzer     <= 1'b0;
        alarm_led  <= 1'b0;
        sec_cnt    <= '0;
        snooze_cnt <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trig) begin
              state_q   <= ST_RINGING;
              buzzer    <= 1'b1;
              alarm_led <= 1'b1;
              sec_cnt   <= '0;
            end
          end
          ST_RINGING: begin
            if (stop_btn) begin
              state_q    <= ST_IDLE;
              buzzer     <= 1'b0;
              alarm_led  <= 1'b0;
              sec_cnt    <= '0;
              snooze_cnt <= '0;
            end else if (snooze_btn && (snooze_cnt < SNZ_MAX)) begin
              state_q    <= ST_SNOOZE;
              buzzer     <= 1'b0;
              sec_cnt    <= '0;
              snooze_cnt <= snooze_cnt + 1'b1;
            end else if (tick_1hz) begin
              if (sec_cnt == RING_LAST) begin
                state_q    <= ST_IDLE;
                buzzer     <= 1'b0;
                alarm_led  <= 1'b0;
                sec_cnt    <= '0;
                snooze_cnt <= '0;
              end else begin
                buzzer  <= !buzzer;
                sec_cnt <= sec_cnt + 1'b1;
              end
            end
          end
          ST_SNOOZE: begin
            if (stop_btn) begin
              state_q    <= ST_IDLE;
              buzzer     <= 1'b0;
              alarm_led  <= 1'b0;
              sec_cnt    <= '0;
              snooze_cnt <= '0;
            end else if (tick_1hz) begin
              if (sec_cnt == SNOOZE_LAST) begin
                state_q <= ST_RINGING;
                buzzer  <= 1'b1;
                sec_cnt <= '0;
              end else begin
                sec_cnt <= sec_cnt + 1'b1;
              end
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            buzzer    <= 1'b0;
            alarm_led <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus random stimulus, checked
// against an integer-level model through an expected-value queue.
module tb_alarm_controller;

  logic        clk;
  logic        reset;
  logic        tick_1hz;
  logic [19:0] time_bus;
  logic        alarm_en;
  logic        set_mode;
  logic        inc_min;
  logic        dec_min;
  logic        inc_hour;
  logic        dec_hour;
  logic        stop_btn;
  logic        snooze_btn;
  logic [12:0] alarm_bcd;
  logic        buzzer;
  logic        alarm_led;
  logic [1:0]  state;

  alarm_controller dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .time_bcd   (time_bus),
    .alarm_en   (alarm_en),
    .set_mode   (set_mode),
    .inc_min    (inc_min),
    .dec_min    (dec_min),
    .inc_hour   (inc_hour),
    .dec_hour   (dec_hour),
    .stop_btn   (stop_btn),
    .snooze_btn (snooze_btn),
    .alarm_bcd  (alarm_bcd),
    .buzzer     (buzzer),
    .alarm_led  (alarm_led),
    .state      (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Alarm held as plain hour/minute integers; ring and snooze phases are
  // tracked as "ticks seen since the phase began".
  int m_ah, m_am;
  int m_state;      // 0 idle, 1 ringing, 2 snooze
  int m_ticks;
  int m_snoozes;
  bit m_prev_match;

  function automatic logic [19:0] mk_time(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [12:0] alarm_of(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  function automatic void model_reset();
    m_ah = 7; m_am = 0;
    m_state = 0; m_ticks = 0; m_snoozes = 0; m_prev_match = 1'b0;
  endfunction

  function automatic void model_step();
    int ht, hu, mt, mu;
    bit hit, rise, edit;
    ht = int'(time_bus[19:18]);
    hu = int'(time_bus[17:14]);
    mt = int'(time_bus[13:11]);
    mu = int'(time_bus[10:7]);
    hit = alarm_en && (hu <= 9) && (mu <= 9) && ((ht * 10 + hu) == m_ah)
       && ((mt * 10 + mu) == m_am) && (time_bus[6:0] == 7'd0);
    rise = hit && !m_prev_match;
    m_prev_match = hit;
    edit = set_mode && (m_state == 0);
    if (!alarm_en) begin
      m_state = 0; m_snoozes = 0;
    end else if (m_state == 0) begin
      if (rise) begin m_state = 1; m_ticks = 0; end
    end else if (stop_btn) begin
      m_state = 0; m_snoozes = 0;
    end else if (m_state == 1 && snooze_btn && m_snoozes < 3) begin
      m_state = 2; m_snoozes++; m_ticks = 0;
    end else if (tick_1hz) begin
      m_ticks++;
      if (m_state == 1 && m_ticks == 60) begin
        m_state = 0; m_snoozes = 0;
      end else if (m_state == 2 && m_ticks == 300) begin
        m_state = 1; m_ticks = 0;
      end
    end
    if (edit) begin
      m_am = (m_am + int'(inc_min) - int'(dec_min) + 60) % 60;
      m_ah = (m_ah + int'(inc_hour) - int'(dec_hour) + 24) % 24;
    end
  endfunction

  function automatic logic [16:0] exp_vec();
    logic bz;
    bz = (m_state == 1) && (m_ticks % 2 == 0);
    return {2'(m_state), bz, (m_state != 0), alarm_of(m_ah, m_am)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  logic [16:0] exp_v;
  logic [16:0] act_v;
  int vectors;
  int miscompares;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {state, buzzer, alarm_led, alarm_bcd};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL vec %0d @%0t: got state=%0d buzzer=%0b led=%0b alarm=%h, required state=%0d buzzer=%0b led=%0b alarm=%h",
                 vectors, $time, act_v[16:15], act_v[14], act_v[13], act_v[12:0],
                 exp_v[16:15], exp_v[14], exp_v[13], exp_v[12:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (!reset) model_reset();
    else        model_step();
    exp_q.push_back(exp_vec());
  endtask

  // Asserted mid-cycle, so the pending expectation for this cycle is replaced.
  task automatic async_reset();
    reset = 1'b0;
    void'(exp_q.pop_back());
    model_reset();
    exp_q.push_back(exp_vec());
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1; step();
      tick_1hz = 1'b0; step();
    end
  endtask

  task automatic clear_pulses();
    tick_1hz = 0; inc_min = 0; dec_min = 0; inc_hour = 0; dec_hour = 0;
    stop_btn = 0; snooze_btn = 0;
  endtask

  // ---------------- stimulus ----------------
  int r;

  initial begin
    vectors = 0; miscompares = 0;
    model_reset();
    reset = 1'b0; alarm_en = 0; set_mode = 0; time_bus = mk_time(12, 0, 30);
    clear_pulses();
    repeat (3) step();
    reset = 1'b1;
    step();

    // Edits: 07:00 -> 3x dec_min, inc_hour -> 08:57
    set_mode = 1;
    repeat (3) begin dec_min = 1; step(); dec_min = 0; step(); end
    inc_hour = 1; step(); inc_hour = 0; step();
    set_mode = 0; inc_min = 1; step(); inc_min = 0; step();
    set_mode = 1;
    dec_hour = 1; step(); dec_hour = 0;
    repeat (3) begin inc_min = 1; step(); inc_min = 0; end
    set_mode = 0;

    // Trigger at 07:00:00, full ring to auto-stop
    alarm_en = 1;
    time_bus = mk_time(6, 59, 59); step();
    time_bus = mk_time(7, 0, 0);   step(); step();
    tick_n(60);
    repeat (3) step();

    // Re-trigger; three snoozes, then a fourth is ignored
    time_bus = mk_time(7, 0, 1); step();
    time_bus = mk_time(7, 0, 0); step();
    repeat (3) begin
      snooze_btn = 1; step(); snooze_btn = 0;
      tick_n(1);
      snooze_btn = 1; step(); snooze_btn = 0;
      tick_n(299);
      tick_n(3);
    end
    snooze_btn = 1; step(); snooze_btn = 0; step(); step();
    set_mode = 1; inc_min = 1; step(); inc_min = 0; set_mode = 0;

    // stop and snooze together, time held at the alarm minute
    stop_btn = 1; snooze_btn = 1; step(); clear_pulses();
    repeat (5) step();

    // Wrap and conflict edits
    time_bus = mk_time(12, 0, 30);
    set_mode = 1;
    repeat (8) begin dec_hour = 1; step(); dec_hour = 0; end
    dec_min = 1; step(); dec_min = 0;
    inc_min = 1; step(); inc_min = 0;
    inc_hour = 1; step(); inc_hour = 0;
    inc_min = 1; dec_min = 1; step(); clear_pulses();
    inc_hour = 1; dec_hour = 1; step(); clear_pulses();
    time_bus = mk_time(1, 1, 15);
    inc_min = 1; inc_hour = 1; step(); clear_pulses();
    set_mode = 0;
    repeat (3) step();
    time_bus = mk_time(1, 1, 0); step(); step();

    // Mid-ring disable, re-enable, then async reset mid-cycle
    tick_n(2);
    alarm_en = 0; step(); step();
    alarm_en = 1; step(); step();
    tick_n(3);
    #1 async_reset();
    step(); step();
    reset = 1'b1;
    step();

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6)       time_bus = {alarm_of(m_ah, m_am), 7'd0};
      else if (r < 9)  time_bus = {alarm_of(m_ah, m_am), 3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      else if (r < 12) time_bus = mk_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      else if (r < 14) time_bus = 20'($urandom);
      alarm_en   = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 19) == 0) set_mode = ($urandom_range(0, 2) == 0);
      tick_1hz   = ($urandom_range(0, 1) == 1);
      inc_min    = ($urandom_range(0, 19) == 0);
      dec_min    = ($urandom_range(0, 19) == 0);
      inc_hour   = ($urandom_range(0, 19) == 0);
      dec_hour   = ($urandom_range(0, 19) == 0);
      stop_btn   = ($urandom_range(0, 49) == 0);
      snooze_btn = ($urandom_range(0, 19) == 0);
      step();
      if ($urandom_range(0, 999) == 0) begin
        async_reset();
        step();
        reset = 1'b1;
      end
    end
    clear_pulses();
    set_mode = 0;
    step();

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unobserved, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
